// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the UDP transmit path: arbiter state,
// payload limit and a width helper.
package eth_tx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      BUSY,
      GAP
   } arb_state_e;

   // One Ethernet frame of UDP payload, no IP fragmentation.
   localparam int UDP_MAX_PAYLOAD = 1472;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/udp_tx_arb_rr.sv
// Combinational round-robin picker: first set request bit searching upward
// from the channel after the previous grant, wrapping at N_CH.
module udp_rr_arb
   import eth_tx_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int GW   = clog2(N_CH)
) (
   input  logic [N_CH-1:0] i_req,
   input  logic [GW-1:0]   i_last,
   output logic [GW-1:0]   o_idx,
   output logic            o_valid
);

   // NOTE: every output gets a default before the search so no latch is inferred.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         if (!o_valid && i_req[(int'(i_last) + k) % N_CH]) begin
            o_valid = 1'b1;
            o_idx   = GW'((int'(i_last) + k) % N_CH);
         end
      end
   end

endmodule

// File: rtl/udp_tx_arb.sv
// N-channel round-robin arbiter in front of a single UDP TX engine.
// Optional BUSY watchdog enabled by defining UDP_TX_ARB_TIMEOUT_EN.
module udp_tx_arb
   import eth_tx_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int DW          = 32,
   parameter int MAX_BYTES   = UDP_MAX_PAYLOAD,
   parameter int GAP_CYC     = 12,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic               gmii_tx_clk,
   input  logic               rst_n,
   input  logic [N_CH-1:0]    ch_start,
   input  logic [N_CH*16-1:0] ch_byte_num,
   input  logic [N_CH*DW-1:0] ch_data,
   output logic [N_CH-1:0]    ch_req,
   output logic [N_CH-1:0]    ch_done,
   output logic [N_CH-1:0]    ch_drop,
   output logic               udp_tx_start_en,
   output logic [15:0]        udp_tx_byte_num,
   output logic [DW-1:0]      udp_tx_data,
   input  logic               udp_tx_req,
   input  logic               udp_tx_done,
   output logic               busy
);

   localparam int GW      = clog2(N_CH);
   localparam int CNT_MAX = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
   localparam int CW      = (clog2(CNT_MAX + 1) < 1) ? 1 : clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   arb_state_e      r_state, w_state_next;
   logic [N_CH-1:0] r_pending, r_done, r_drop;
   logic [15:0]     r_len [N_CH];
   logic [15:0]     r_tx_len;
   logic [GW-1:0]   r_grant, r_last;
   logic [CW-1:0]   r_cnt;
   logic [GW-1:0]   w_pick;
   logic            w_pick_valid;
   logic [N_CH-1:0] w_grant_oh;
   logic            w_done_evt, w_timeout, w_cnt_run;

   function automatic logic len_ok(input logic [15:0] n);
      return (n != 16'd0) && (n <= 16'(MAX_BYTES));
   endfunction

   assign w_grant_oh = N_CH'(1) << r_grant;
   assign w_done_evt = (r_state == BUSY) && udp_tx_done;

`ifdef UDP_TX_ARB_TIMEOUT_EN
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
   assign w_timeout = (r_state == BUSY) && !udp_tx_done && (r_cnt == TIMEOUT_LAST);
   assign w_cnt_run = (r_state == GAP) || (r_state == BUSY);
`else
   assign w_timeout = 1'b0;
   assign w_cnt_run = (r_state == GAP);
`endif

   udp_rr_arb #(.N_CH(N_CH), .GW(GW)) u_rr (
      .i_req   (r_pending),
      .i_last  (r_last),
      .o_idx   (w_pick),
      .o_valid (w_pick_valid)
   );

   always_ff @(posedge gmii_tx_clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_pick_valid) w_state_next = GRANT;
         GRANT:   w_state_next = BUSY;
         BUSY:    if (w_done_evt || w_timeout) w_state_next = (GAP_CYC > 0) ? GAP : IDLE;
         GAP:     if (r_cnt == GAP_LAST) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge gmii_tx_clk) begin
      if (!rst_n) begin
         r_pending <= '0;
         r_done    <= '0;
         r_drop    <= '0;
         r_tx_len  <= '0;
         r_grant   <= '0;
         r_last    <= GW'(N_CH - 1);
         r_cnt     <= '0;
         // NOTE: the length table is tiny, so it is reset like ordinary flops.
         for (int i = 0; i < N_CH; i++) r_len[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            r_drop[i] <= (ch_start[i] && (r_pending[i] || !len_ok(ch_byte_num[i*16 +: 16])))
                         || (w_timeout && w_grant_oh[i]);
            if (ch_start[i] && !r_pending[i] && len_ok(ch_byte_num[i*16 +: 16])) begin
               r_pending[i] <= 1'b1;
               r_len[i]     <= ch_byte_num[i*16 +: 16];
            end else if ((r_state == GRANT) && w_grant_oh[i]) begin
               r_pending[i] <= 1'b0;
            end
         end
         r_done <= w_done_evt ? w_grant_oh : '0;
         // Length is snapshotted so a re-request by the grantee cannot disturb it.
         if ((r_state == IDLE) && w_pick_valid) begin
            r_grant  <= w_pick;
            r_tx_len <= r_len[w_pick];
         end
         if (r_state == GRANT) r_last <= r_grant;
         if (r_state != w_state_next) r_cnt <= '0;
         else if (w_cnt_run)          r_cnt <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      udp_tx_start_en = (r_state == GRANT);
      udp_tx_byte_num = '0;
      ch_req          = '0;
      udp_tx_data     = '0;
      if ((r_state == GRANT) || (r_state == BUSY)) udp_tx_byte_num = r_tx_len;
      if (r_state == BUSY) begin
         ch_req      = udp_tx_req ? w_grant_oh : '0;
         udp_tx_data = ch_data[int'(r_grant)*DW +: DW];
      end
      busy    = (r_state != IDLE);
      ch_done = r_done;
      ch_drop = r_drop;
   end

endmodule

// File: tb/tb_udp_tx_arb.sv
// Self-checking bench for udp_tx_arb: capture-rule table, hand sequences for
// round-robin, fairness, reset and watchdog, then random traffic vs a model.
module tb_udp_tx_arb;

   localparam int N_CH        = 4;
   localparam int DW          = 32;
   localparam int MAX_BYTES   = 1472;
   localparam int GAP_CYC     = 12;
   localparam int TIMEOUT_CYC = 100;

   logic               gmii_tx_clk;
   logic               rst_n;
   logic [N_CH-1:0]    ch_start;
   logic [N_CH*16-1:0] ch_byte_num;
   logic [N_CH*DW-1:0] ch_data;
   logic [N_CH-1:0]    ch_req, ch_done, ch_drop;
   logic               udp_tx_start_en;
   logic [15:0]        udp_tx_byte_num;
   logic [DW-1:0]      udp_tx_data;
   logic               udp_tx_req, udp_tx_done, busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   udp_tx_arb #(
      .N_CH(N_CH), .DW(DW), .MAX_BYTES(MAX_BYTES),
      .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .gmii_tx_clk     (gmii_tx_clk),
      .rst_n           (rst_n),
      .ch_start        (ch_start),
      .ch_byte_num     (ch_byte_num),
      .ch_data         (ch_data),
      .ch_req          (ch_req),
      .ch_done         (ch_done),
      .ch_drop         (ch_drop),
      .udp_tx_start_en (udp_tx_start_en),
      .udp_tx_byte_num (udp_tx_byte_num),
      .udp_tx_data     (udp_tx_data),
      .udp_tx_req      (udp_tx_req),
      .udp_tx_done     (udp_tx_done),
      .busy            (busy)
   );

   initial gmii_tx_clk = 1'b0;
   always #5 gmii_tx_clk = ~gmii_tx_clk;

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int ch;
      int len;
      bit exp_drop;
      bit exp_start;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge and clear the pulse inputs.
   task automatic tick();
      @(posedge gmii_tx_clk);
      #1;
      ch_start    = '0;
      udp_tx_done = 1'b0;
      cyc++;
   endtask

   task automatic set_len(input int ch, input int len);
      ch_byte_num[ch*16 +: 16] = 16'(len);
      ch_start[ch]             = 1'b1;
   endtask

   function automatic logic [DW-1:0] tag(input int ch);
      return 32'hDA7A_0000 | 32'(ch);
   endfunction

   task automatic load_data();
      for (int i = 0; i < N_CH; i++) ch_data[i*DW +: DW] = tag(i);
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      ch_start    = '0;
      ch_byte_num = '0;
      ch_data     = '0;
      udp_tx_req  = 1'b0;
      udp_tx_done = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_start(input string name, input int budget, output bit ok);
      int n;
      n = 0;
      #1;
      while (udp_tx_start_en !== 1'b1 && n < budget) begin
         tick();
         #1;
         n++;
      end
      ok = (udp_tx_start_en === 1'b1);
      check($sformatf("%s_start_seen", name), ok, 1);
   endtask

   task automatic no_start(input string name, input int budget);
      int seen;
      seen = 0;
      for (int n = 0; n < budget; n++) begin
         tick();
         #1;
         if (udp_tx_start_en === 1'b1) seen++;
      end
      check($sformatf("%s_no_start", name), seen, 0);
   endtask

   // Plays the engine for one frame: expects a grant of ch/len, streams words,
   // then pulses tx_done and expects ch_done on the following cycle.
   task automatic run_frame(input string name, input int ch, input int len, input int words,
                            input int rereq_ch, input int rereq_len,
                            output int start_cyc, output int done_cyc);
      bit ok;
      wait_start(name, 200, ok);
      start_cyc = cyc;
      done_cyc  = cyc;
      if (ok) begin
         check($sformatf("%s_len", name), udp_tx_byte_num, len);
         for (int w = 0; w < words; w++) begin
            tick();
            udp_tx_req = 1'b1;
            if (w == 0 && rereq_ch >= 0) set_len(rereq_ch, rereq_len);
            #1;
            check($sformatf("%s_req_w%0d", name, w), ch_req, 64'(1) << ch);
            check($sformatf("%s_data_w%0d", name, w), udp_tx_data, tag(ch));
         end
         tick();
         udp_tx_req  = 1'b0;
         udp_tx_done = 1'b1;
         #1;
         check($sformatf("%s_done_early", name), ch_done, 0);
         tick();
         #1;
         check($sformatf("%s_done", name), ch_done, 64'(1) << ch);
         done_cyc = cyc;
      end
   endtask

   function automatic int rand_len();
      case ($urandom % 8)
         0:       return 0;
         1:       return 1473 + int'($urandom % 1000);
         2:       return 1472;
         3:       return 1;
         default: return int'($urandom_range(1, 1472));
      endcase
   endfunction

   // Model: per-channel pending/length/accept-cycle, a round-robin pointer and the
   // earliest cycle a new start may appear (start needs a request accepted >= 2
   // cycles earlier and GAP_CYC idle cycles plus one pick cycle after tx_done).
   task automatic random_test(input int ncyc);
      bit              m_pend [N_CH];
      int              m_len  [N_CH];
      int              m_acc  [N_CH];
      int              st_len [N_CH];
      int              m_last, m_free, g_ch, g_len, done_at, pick;
      bit              granted, exp_start;
      logic [N_CH-1:0] e_done, e_drop;
      do_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_pend[i] = 1'b0;
         m_len[i]  = 0;
         m_acc[i]  = 0;
      end
      m_last  = N_CH - 1;
      m_free  = 0;
      granted = 1'b0;
      g_ch    = 0;
      g_len   = 0;
      done_at = 0;
      e_done  = '0;
      e_drop  = '0;
      for (int c = 0; c < ncyc; c++) begin
         tick();
         pick = -1;
         if (!granted && c >= m_free) begin
            for (int k = 1; k <= N_CH; k++) begin
               int j;
               j = (m_last + k) % N_CH;
               if (pick < 0 && m_pend[j] && m_acc[j] <= c - 2) pick = j;
            end
         end
         exp_start = (pick >= 0);
         for (int i = 0; i < N_CH; i++) begin
            ch_data[i*DW +: DW] = $urandom;
            if ($urandom % 10 == 0) begin
               st_len[i] = rand_len();
               set_len(i, st_len[i]);
            end
         end
         udp_tx_req  = 1'($urandom % 2);
         udp_tx_done = granted ? (c == done_at) : ($urandom % 16 == 0);
         #1;
         check("rnd_start", udp_tx_start_en, exp_start);
         if (exp_start) begin
            check("rnd_grant_len", udp_tx_byte_num, m_len[pick]);
            check("rnd_grant_req", ch_req, 0);
         end else if (granted) begin
            check("rnd_busy_len", udp_tx_byte_num, g_len);
            check("rnd_busy_req", ch_req, udp_tx_req ? (64'(1) << g_ch) : 64'(0));
            check("rnd_busy_data", udp_tx_data, ch_data[g_ch*DW +: DW]);
         end else begin
            check("rnd_idle_len", udp_tx_byte_num, 0);
            check("rnd_idle_req", ch_req, 0);
         end
         check("rnd_done", ch_done, e_done);
         check("rnd_drop", ch_drop, e_drop);
         check("rnd_busy", busy, exp_start || granted || (c < m_free - 1));
         e_drop = '0;
         e_done = '0;
         for (int i = 0; i < N_CH; i++) begin
            if (ch_start[i]) begin
               if (m_pend[i] || st_len[i] == 0 || st_len[i] > MAX_BYTES) begin
                  e_drop[i] = 1'b1;
               end else begin
                  m_pend[i] = 1'b1;
                  m_len[i]  = st_len[i];
                  m_acc[i]  = c;
               end
            end
         end
         if (exp_start) begin
            m_pend[pick] = 1'b0;
            m_last       = pick;
            granted      = 1'b1;
            g_ch         = pick;
            g_len        = m_len[pick];
            done_at      = c + int'($urandom_range(1, 8));
         end else if (granted && c == done_at) begin
            e_done[g_ch] = 1'b1;
            granted      = 1'b0;
            m_free       = c + GAP_CYC + 2;
         end
      end
   endtask

   initial begin
      vec_t tbl [8];
      int   s0, d0, s1, d1;
      bit   ok;

      rst_n       = 1'b0;
      ch_start    = '0;
      ch_byte_num = '0;
      ch_data     = '0;
      udp_tx_req  = 1'b0;
      udp_tx_done = 1'b0;

      // Reset state, with a stray tx_req that must not reach any channel.
      do_reset();
      udp_tx_req = 1'b1;
      #1;
      check("rst_start", udp_tx_start_en, 0);
      check("rst_len", udp_tx_byte_num, 0);
      check("rst_req", ch_req, 0);
      check("rst_done", ch_done, 0);
      check("rst_drop", ch_drop, 0);
      check("rst_busy", busy, 0);
      udp_tx_req = 1'b0;

      // Capture rules: lengths 0 and >MAX_BYTES are dropped, others start at t+2.
      tbl[0] = '{0, 64,    1'b0, 1'b1};
      tbl[1] = '{1, 0,     1'b1, 1'b0};
      tbl[2] = '{2, 1473,  1'b1, 1'b0};
      tbl[3] = '{3, 1472,  1'b0, 1'b1};
      tbl[4] = '{1, 1,     1'b0, 1'b1};
      tbl[5] = '{2, 65535, 1'b1, 1'b0};
      tbl[6] = '{3, 0,     1'b1, 1'b0};
      tbl[7] = '{0, 1000,  1'b0, 1'b1};
      for (int v = 0; v < 8; v++) begin
         do_reset();
         tick();
         set_len(tbl[v].ch, tbl[v].len);
         #1;
         check($sformatf("tbl%0d_t0_start", v), udp_tx_start_en, 0);
         tick();
         #1;
         check($sformatf("tbl%0d_drop", v), ch_drop, 64'(tbl[v].exp_drop) << tbl[v].ch);
         check($sformatf("tbl%0d_t1_start", v), udp_tx_start_en, 0);
         tick();
         #1;
         check($sformatf("tbl%0d_start", v), udp_tx_start_en, tbl[v].exp_start);
         check($sformatf("tbl%0d_len", v), udp_tx_byte_num, tbl[v].exp_start ? tbl[v].len : 0);
      end

      // Single frame on ch0, including return to idle after the gap.
      do_reset();
      load_data();
      tick();
      set_len(0, 64);
      s0 = cyc;
      run_frame("single", 0, 64, 3, -1, 0, s1, d1);
      check("single_latency", s1 - s0, 2);
      #1;
      check("single_gap_busy", busy, 1);
      check("single_gap_len", udp_tx_byte_num, 0);
      repeat (GAP_CYC) tick();
      #1;
      check("single_idle", busy, 0);

      // Round-robin over four simultaneous requests, gap honoured between grants.
      do_reset();
      load_data();
      tick();
      for (int i = 0; i < N_CH; i++) set_len(i, 16);
      d0 = 0;
      for (int i = 0; i < N_CH; i++) begin
         run_frame($sformatf("rr%0d", i), i, 16, 2, -1, 0, s1, d1);
         if (i > 0) check($sformatf("rr%0d_gap", i), (s1 - d0) >= GAP_CYC + 1, 1);
         d0 = d1;
      end

      // Repeated start on a pending channel is dropped; original length kept.
      do_reset();
      load_data();
      tick();
      set_len(1, 100);
      tick();
      set_len(1, 200);
      tick();
      #1;
      check("rep_drop", ch_drop, 4'b0010);
      run_frame("rep", 1, 100, 2, -1, 0, s1, d1);
      no_start("rep", GAP_CYC + 10);

      // Fairness: ch1 re-requests during its own frame while ch2 waits.
      do_reset();
      load_data();
      tick();
      set_len(1, 20);
      set_len(2, 24);
      run_frame("fair0", 1, 20, 3, 1, 28, s1, d1);
      run_frame("fair1", 2, 24, 3, -1, 0, s1, d1);
      run_frame("fair2", 1, 28, 3, -1, 0, s1, d1);

      // Reset mid-frame at word 5 with another request pending.
      do_reset();
      load_data();
      tick();
      set_len(3, 40);
      wait_start("mrst", 20, ok);
      for (int w = 0; w < 5; w++) begin
         tick();
         udp_tx_req = 1'b1;
         if (w == 1) set_len(1, 10);
         if (w == 4) rst_n = 1'b0;
      end
      tick();
      rst_n       = 1'b1;
      udp_tx_done = 1'b1;
      #1;
      check("mrst_start", udp_tx_start_en, 0);
      check("mrst_len", udp_tx_byte_num, 0);
      check("mrst_req", ch_req, 0);
      check("mrst_data", udp_tx_data, 0);
      check("mrst_drop", ch_drop, 0);
      check("mrst_busy", busy, 0);
      tick();
      #1;
      check("mrst_no_done", ch_done, 0);
      udp_tx_req = 1'b0;
      no_start("mrst", GAP_CYC + 10);

`ifdef UDP_TX_ARB_TIMEOUT_EN
      // Watchdog: withheld tx_done aborts after TIMEOUT_CYC busy cycles.
      begin
         int  g, n, dones;
         bit  seen;
         do_reset();
         load_data();
         tick();
         set_len(2, 50);
         wait_start("to", 20, ok);
         g     = cyc;
         n     = 0;
         dones = 0;
         seen  = 1'b0;
         while (!seen && n < 300) begin
            tick();
            if (n == 0) set_len(0, 30);
            udp_tx_req = 1'(n % 2);
            #1;
            if (ch_done != 0) dones++;
            if (ch_drop[2]) seen = 1'b1;
            n++;
         end
         check("to_drop_seen", seen, 1);
         check("to_drop_cycle", cyc - g, TIMEOUT_CYC + 1);
         check("to_no_done", dones, 0);
         tick();
         udp_tx_req  = 1'b0;
         udp_tx_done = 1'b1;
         #1;
         tick();
         #1;
         check("to_late_done", ch_done, 0);
         run_frame("to_next", 0, 30, 2, -1, 0, s1, d1);
      end
`endif

      random_test(4000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
